// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key decoder.
//   - Scan-code prefix bytes (E0 extended, F0 break)
//   - Keyboard control/status bytes that never carry key data
//   - 5-bit calculator key codes (KEY_NONE marks an unmapped scan code)
//   - Prefix FSM state encoding
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;

  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  localparam logic [4:0] KEY_0     = 5'h00;
  localparam logic [4:0] KEY_1     = 5'h01;
  localparam logic [4:0] KEY_2     = 5'h02;
  localparam logic [4:0] KEY_3     = 5'h03;
  localparam logic [4:0] KEY_4     = 5'h04;
  localparam logic [4:0] KEY_5     = 5'h05;
  localparam logic [4:0] KEY_6     = 5'h06;
  localparam logic [4:0] KEY_7     = 5'h07;
  localparam logic [4:0] KEY_8     = 5'h08;
  localparam logic [4:0] KEY_9     = 5'h09;
  localparam logic [4:0] KEY_ADD   = 5'h0A;
  localparam logic [4:0] KEY_SUB   = 5'h0B;
  localparam logic [4:0] KEY_MUL   = 5'h0C;
  localparam logic [4:0] KEY_DIV   = 5'h0D;
  localparam logic [4:0] KEY_ENTER = 5'h0E;
  localparam logic [4:0] KEY_CLR   = 5'h0F;
  localparam logic [4:0] KEY_BS    = 5'h10;
  localparam logic [4:0] KEY_NONE  = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } pfx_state_e;

  // Bytes the keyboard sends for its own housekeeping; they abort any prefix.
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return b inside {SC_BAT_OK, SC_ACK, SC_RESEND, SC_ECHO, SC_ERR0, SC_ERR1};
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Synchronous key-event FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   push_i, wdata_i : write request and entry {ext, code[4:0]}
//   pop_i           : read request (ignored while empty)
//   rdata_o         : entry at the head (only meaningful while !empty_o)
//   full_o, empty_o : occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module ps2_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];

  // Storage carries no reset; the head is qualified by empty_o downstream.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code to calculator key decoder.
//   clk, rst   : clock, synchronous active-high reset
//   rx_data    : scan-code byte, qualified by the one-cycle rx_valid strobe
//   key_ready  : consumer accepts the head event (pop when key_valid too)
//   key_valid  : at least one buffered event
//   key_code   : head key code (0 while empty)
//   key_ext    : head event was E0-prefixed (0 while empty)
//   overflow   : one-cycle pulse when an event was dropped on a full buffer
// Prefix bytes are tracked by a small FSM; make codes of mapped keys are
// buffered, typematic repeats of the held key are optionally suppressed,
// and break codes only release the held key.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_REPEAT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [4:0] key_code,
  output logic       key_ext,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  function automatic logic [4:0] lookup_key(input logic ext, input logic [7:0] sc);
    logic [4:0] k;
    k = KEY_NONE;
    if (ext) begin
      case (sc)
        8'h4A:   k = KEY_DIV;
        8'h5A:   k = KEY_ENTER;
        default: k = KEY_NONE;
      endcase
    end else begin
      case (sc)
        8'h70:   k = KEY_0;
        8'h69:   k = KEY_1;
        8'h72:   k = KEY_2;
        8'h7A:   k = KEY_3;
        8'h6B:   k = KEY_4;
        8'h73:   k = KEY_5;
        8'h74:   k = KEY_6;
        8'h6C:   k = KEY_7;
        8'h75:   k = KEY_8;
        8'h7D:   k = KEY_9;
        8'h79:   k = KEY_ADD;
        8'h7B:   k = KEY_SUB;
        8'h7C:   k = KEY_MUL;
        8'h5A:   k = KEY_ENTER;
        8'h76:   k = KEY_CLR;
        8'h66:   k = KEY_BS;
        default: k = KEY_NONE;
      endcase
    end
    return k;
  endfunction

  pfx_state_e    state_q;
  logic [TW-1:0] tmo_q;
  logic          held_valid_q;
  logic [5:0]    held_key_q;
  logic          overflow_q;

  logic          is_ctrl;
  logic          is_pfx;
  logic          ev_fire;
  logic          ev_ext;
  logic          ev_brk;
  logic [4:0]    ev_code;
  logic [5:0]    ev_key;
  logic          ev_known;
  logic          repeat_hit;
  logic          push;
  logic          release_held;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [5:0]    head;

  // Classify the incoming byte against the prefix collected so far.
  always_comb begin
    is_ctrl      = is_ctrl_byte(rx_data);
    is_pfx       = (rx_data == SC_EXT) || (rx_data == SC_BRK);
    ev_ext       = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    ev_brk       = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    ev_fire      = rx_valid && !is_ctrl && !is_pfx;
    ev_code      = lookup_key(ev_ext, rx_data);
    ev_key       = {ev_ext, ev_code};
    ev_known     = (ev_code != KEY_NONE);
    repeat_hit   = (FILTER_REPEAT != 0) && held_valid_q && (held_key_q == ev_key);
    push         = ev_fire && ev_known && !ev_brk && !repeat_hit;
    release_held = ev_fire && ev_known && ev_brk && held_valid_q && (held_key_q == ev_key);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tmo_q        <= '0;
      held_valid_q <= 1'b0;
      held_key_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      overflow_q <= push && fifo_full && !pop;

      // The held key follows every accepted make, even one lost to overflow.
      if (push) begin
        held_valid_q <= 1'b1;
        held_key_q   <= ev_key;
      end else if (release_held) begin
        held_valid_q <= 1'b0;
      end

      if (rx_valid) begin
        tmo_q <= '0;
        if (is_ctrl) begin
          state_q <= ST_IDLE;
        end else begin
          case (state_q)
            ST_IDLE:    state_q <= (rx_data == SC_EXT) ? ST_EXT :
                                   (rx_data == SC_BRK) ? ST_BRK : ST_IDLE;
            ST_EXT:     state_q <= (rx_data == SC_BRK) ? ST_EXT_BRK :
                                   (rx_data == SC_EXT) ? ST_EXT : ST_IDLE;
            ST_BRK:     state_q <= (rx_data == SC_EXT) ? ST_EXT_BRK :
                                   (rx_data == SC_BRK) ? ST_BRK : ST_IDLE;
            ST_EXT_BRK: state_q <= is_pfx ? ST_EXT_BRK : ST_IDLE;
            default:    state_q <= ST_IDLE;
          endcase
        end
      end else if (state_q != ST_IDLE) begin
        // A stalled prefix is abandoned so a lost byte cannot corrupt the next key.
        if (tmo_q == TO_LAST) begin
          state_q <= ST_IDLE;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign pop = key_valid && key_ready;

  ps2_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (6)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (ev_key),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign key_valid = !fifo_empty;
  assign key_code  = key_valid ? head[4:0] : 5'h00;
  assign key_ext   = key_valid && head[5];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed sequences with literal
// expectations, then randomized byte streams, both compared every cycle
// against a queue-based reference model. Two instances run side by side,
// one with repeat filtering and one without.
module tb_ps2_key_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       key_ready;
  logic       kv0, ext0, ovf0;
  logic [4:0] kc0;
  logic       kv1, ext1, ovf1;
  logic [4:0] kc1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .FILTER_REPEAT(1)) u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .key_ready(key_ready),
    .key_valid(kv0), .key_code(kc0), .key_ext(ext0), .overflow(ovf0));

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .FILTER_REPEAT(0)) u_dut_nf (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .key_ready(key_ready),
    .key_valid(kv1), .key_code(kc1), .key_ext(ext1), .overflow(ovf1));

  int checks = 0;
  int errors = 0;

  // Reference model: prefix flags, idle gap, and per-instance queue/held key.
  logic [5:0] mq0[$];
  logic [5:0] mq1[$];
  int  held0, held1;      // -1 means no key held
  bit  mov0, mov1;
  bit  pf_ext, pf_brk;
  int  gap;
  bit  model_ok = 1'b0;
  int  pops0, pops1;

  function automatic int model_key(input bit ext, input logic [7:0] b);
    if (ext) begin
      if (b == 8'h4A) return 13;
      if (b == 8'h5A) return 14;
      return -1;
    end
    case (b)
      8'h70: return 0;  8'h69: return 1;  8'h72: return 2;  8'h7A: return 3;
      8'h6B: return 4;  8'h73: return 5;  8'h74: return 6;  8'h6C: return 7;
      8'h75: return 8;  8'h7D: return 9;  8'h79: return 10; 8'h7B: return 11;
      8'h7C: return 12; 8'h5A: return 14; 8'h76: return 15; 8'h66: return 16;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit p0, p1, fire, is_make;
    int key;
    if (rst) begin
      mq0.delete(); mq1.delete();
      held0 = -1; held1 = -1; mov0 = 0; mov1 = 0;
      pf_ext = 0; pf_brk = 0; gap = 0;
      return;
    end
    p0 = (mq0.size() > 0) && key_ready;
    p1 = (mq1.size() > 0) && key_ready;
    fire = 0; is_make = 0; key = -1;
    if (rx_valid) begin
      gap = 0;
      if (rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
        pf_ext = 0; pf_brk = 0;
      end else if (rx_data == 8'hE0) begin
        pf_ext = 1;
      end else if (rx_data == 8'hF0) begin
        pf_brk = 1;
      end else begin
        key = model_key(pf_ext, rx_data);
        if (key >= 0) begin
          fire = 1;
          is_make = !pf_brk;
          if (pf_ext) key = key + 32;
        end
        pf_ext = 0; pf_brk = 0;
      end
    end else if (pf_ext || pf_brk) begin
      gap++;
      if (gap >= TMO) begin pf_ext = 0; pf_brk = 0; end
    end
    // Instance 0: repeats of the held key are dropped.
    mov0 = 0;
    if (fire && is_make) begin
      if (held0 != key) begin
        if (mq0.size() < DEPTH || p0) mq0.push_back(key[5:0]); else mov0 = 1;
        held0 = key;
      end
    end else if (fire && held0 == key) begin
      held0 = -1;
    end
    if (p0) void'(mq0.pop_front());
    // Instance 1: every make is enqueued.
    mov1 = 0;
    if (fire && is_make) begin
      if (mq1.size() < DEPTH || p1) mq1.push_back(key[5:0]); else mov1 = 1;
      held1 = key;
    end else if (fire && held1 == key) begin
      held1 = -1;
    end
    if (p1) void'(mq1.pop_front());
  endtask

  task automatic compare_all();
    chk("kv0",  kv0,  mq0.size() > 0);
    chk("kc0",  kc0,  mq0.size() > 0 ? 32'(mq0[0][4:0]) : 32'd0);
    chk("ext0", ext0, mq0.size() > 0 ? 32'(mq0[0][5]) : 32'd0);
    chk("ovf0", ovf0, mov0);
    chk("kv1",  kv1,  mq1.size() > 0);
    chk("kc1",  kc1,  mq1.size() > 0 ? 32'(mq1[0][4:0]) : 32'd0);
    chk("ext1", ext1, mq1.size() > 0 ? 32'(mq1[0][5]) : 32'd0);
    chk("ovf1", ovf1, mov1);
  endtask

  // One clock: check outputs at the falling edge, advance the model with the
  // inputs the DUT is about to sample, then return just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (model_ok) compare_all();
    if (kv0 && key_ready) pops0++;
    if (kv1 && key_ready) pops1++;
    model_step();
    if (rst) model_ok = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
    $display("byte %02h -> kv0=%0b kc0=%02h ext0=%0b ovf0=%0b | kv1=%0b kc1=%02h", b, kv0, kc0, ext0, ovf0, kv1, kc1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0;
    cycle();
    rst = 1'b0;
    pops0 = 0; pops1 = 0;
  endtask

  logic [7:0] known_sc [16] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C,
                                8'h75, 8'h7D, 8'h79, 8'h7B, 8'h7C, 8'h5A, 8'h76, 8'h66};
  logic [7:0] ctrl_sc  [6]  = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; key_ready = 1'b0;
    do_reset();
    chk("reset_kv",  kv0,  0);
    chk("reset_kc",  kc0,  0);
    chk("reset_ext", ext0, 0);
    chk("reset_ovf", ovf0, 0);

    // Single make then break: one event, break silent.
    key_ready = 1'b1;
    send(8'h69);
    chk("t1_kv", kv0, 1);
    chk("t1_kc", kc0, 5'h01);
    chk("t1_ext", ext0, 0);
    idle(1);
    send(8'hF0); send(8'h69); idle(2);
    chk("t1_pops", pops0, 1);

    // Typematic repeats.
    do_reset();
    key_ready = 1'b1;
    send(8'h72); send(8'h72); send(8'h72); send(8'hF0); send(8'h72); send(8'h72);
    idle(3);
    chk("t2_pops_filter", pops0, 2);
    chk("t2_pops_nofilter", pops1, 4);

    // Extended keys held while the consumer stalls.
    do_reset();
    key_ready = 1'b0;
    send(8'hE0); send(8'h4A); send(8'h5A); send(8'hE0); send(8'h5A);
    chk("t3_head_kc", kc0, 5'h0D);
    chk("t3_head_ext", ext0, 1);
    idle(3);
    chk("t3_stable_kc", kc0, 5'h0D);
    key_ready = 1'b1;
    chk("t3_e0_kc", kc0, 5'h0D); cycle();
    chk("t3_e1_kc", kc0, 5'h0E); chk("t3_e1_ext", ext0, 0); cycle();
    chk("t3_e2_kc", kc0, 5'h0E); chk("t3_e2_ext", ext0, 1); cycle();
    chk("t3_empty", kv0, 0);

    // Overflow on the fifth make.
    do_reset();
    key_ready = 1'b0;
    send(8'h70); send(8'h69); send(8'h72); send(8'h7A);
    chk("t4_no_ovf", ovf0, 0);
    send(8'h6B);
    chk("t4_ovf_pulse", ovf0, 1);
    idle(1);
    chk("t4_ovf_clear", ovf0, 0);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", kc0, i);
      cycle();
    end
    chk("t4_drained", kv0, 0);

    // Prefix timeout boundary.
    do_reset();
    key_ready = 1'b0;
    send(8'hF0); idle(TMO); send(8'h73);
    chk("t5_make_kv", kv0, 1);
    chk("t5_make_kc", kc0, 5'h05);
    key_ready = 1'b1; idle(1);
    send(8'hF0); idle(TMO - 1); send(8'h73); idle(1);
    chk("t5_break_kv0", kv0, 0);
    chk("t5_break_kv1", kv1, 0);

    // Control/unknown bytes, then reset in the middle of a prefix.
    do_reset();
    key_ready = 1'b1;
    send(8'hAA); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h4A);
    chk("t6_no_events", pops0, 0);
    rst = 1'b1; rx_data = 8'hE0; rx_valid = 1'b1;
    cycle();
    rst = 1'b0; rx_valid = 1'b0;
    chk("t6_rst_kv", kv0, 0);
    chk("t6_rst_kc", kc0, 0);
    chk("t6_rst_ovf", ovf0, 0);
    send(8'h7D);
    chk("t6_kc", kc0, 5'h09);
    chk("t6_ext", ext0, 0);

    // Randomized streams against the model.
    for (int n = 0; n < 4000; n++) begin
      int r;
      if (n % 250 == 0) key_ready = 1'b0;
      key_ready = ($urandom_range(0, 3) != 0) ? ~key_ready | ($urandom_range(0, 1) == 1) : key_ready;
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rx_valid = 1'b0;
        idle($urandom_range(TMO - 2, TMO + 2));
      end
      rx_valid = ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 99);
      if (r < 20)      rx_data = 8'hE0;
      else if (r < 35) rx_data = 8'hF0;
      else if (r < 85) rx_data = known_sc[$urandom_range(0, 15)];
      else if (r < 92) rx_data = ctrl_sc[$urandom_range(0, 5)];
      else             rx_data = 8'($urandom_range(0, 255));
      cycle();
      if (rx_valid)
        $display("rand byte %02h rst=%0b rdy=%0b -> kv0=%0b kc0=%02h kv1=%0b kc1=%02h", rx_data, rst, key_ready, kv0, kc0, kv1, kc1);
    end
    rst = 1'b0; rx_valid = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
